csi_packet_controller: RTL and testbench
========================================

Name: csi_packet_controller

Overview:
- Sequences a single D-PHY data lane receiver (byte stream `data`/`enable` plus synchronous `reset` input) at the CSI-2 packet level.
- Parses the 4-byte packet header and counts payload bytes from the word count.
- Captures the 2-byte footer, then asserts the receiver reset for a fixed window so the receiver re-arms for the next sync byte.
- Recovers from stalled lanes with a byte-gap timeout.

Parameters:
- RESYNC_CYCLES, 4: cycles `phy_reset` is held high after each packet, timeout, or reset release; range 1..255.
- TIMEOUT_CYCLES, 64: maximum cycles with no `rx_enable` while mid-packet before abort; range 2..65535.

Ports:
- clock  input  1  receiver byte clock.
- reset  input  1  asynchronous, active-high.
- rx_data  input  8  byte from the lane receiver.
- rx_enable  input  1  `rx_data` valid this cycle.
- phy_reset  output  1  synchronous reset driven to the lane receiver.
- virtual_channel  output  2  header byte0[7:6].
- data_type  output  6  header byte0[5:0].
- word_count  output  16  {byte2, byte1}.
- ecc  output  8  header byte3, passed through unchecked.
- header_valid  output  1  one-cycle pulse, header fields valid.
- payload  output  8  payload byte.
- payload_valid  output  1  one-cycle pulse per payload byte.
- footer  output  16  {second footer byte, first footer byte} (checksum, unchecked).
- packet_done  output  1  one-cycle pulse, packet complete.
- timeout_error  output  1  one-cycle pulse, packet aborted.

Behaviour:
- Reset is asynchronous and active-high. While `reset` is asserted:
  - state=RESYNC, resync counter=0, `phy_reset`=1.
  - All pulse outputs = 0.
  - Header fields, `payload` and `footer` = 0.
- States: IDLE, HEADER, PAYLOAD, FOOTER, RESYNC. `phy_reset` = 1 iff state==RESYNC (registered output).
- RESYNC:
  - Counter increments each cycle.
  - Transition to IDLE on the edge where the counter reaches RESYNC_CYCLES-1, so `phy_reset` is high exactly RESYNC_CYCLES cycles.
  - Counter clears on entry.
  - `rx_enable` is ignored.
- IDLE:
  - `rx_enable` captures byte0 into `virtual_channel`/`data_type`.
  - Header index set to 1, go to HEADER.
- HEADER:
  - Bytes 1, 2, 3 load `word_count[7:0]`, `word_count[15:8]`, `ecc`.
  - On byte3: `header_valid`=1 in the following cycle.
  - Short packet (`data_type` < 6'h10): `packet_done`=1 in that same cycle, go to RESYNC.
  - Long packet with `word_count`==0: go to FOOTER.
  - Otherwise load the remaining count = `word_count` and go to PAYLOAD.
- PAYLOAD:
  - Each `rx_enable` registers `payload`=`rx_data`; `payload_valid`=1 in the next cycle (1-cycle latency). The remaining count decrements.
  - The byte that takes the remaining count from 1 to 0 goes to FOOTER.
  - `word_count`=16'hFFFF is legal; no wrap-around occurs.
- FOOTER:
  - First byte loads `footer[7:0]`, second byte loads `footer[15:8]`.
  - On the second byte: `packet_done`=1 in the next cycle, go to RESYNC.
- Timeout:
  - The gap counter runs in HEADER/PAYLOAD/FOOTER and clears on every accepted byte and on state entry.
  - If TIMEOUT_CYCLES consecutive cycles pass without `rx_enable`: `timeout_error`=1 for one cycle, go to RESYNC.
  - No `packet_done` is issued for an aborted packet.
  - If `rx_enable` arrives in the same cycle the limit would be reached, the byte wins and there is no timeout.
- Header fields and `footer` hold until overwritten by the next packet. `payload` holds its last value between pulses.
- Pulses never overlap, except `header_valid`+`packet_done` for short packets.
- Async reset mid-packet aborts immediately, with no `packet_done` or `timeout_error`.

Test Plan:
- Reset release → `phy_reset`=1 for exactly 4 cycles after `reset` falls, then 0; state IDLE; all pulses 0 throughout.
- Short packet, bytes 8'h00, 8'h01, 8'h00, 8'h07 on consecutive enables:
  - One cycle after the 4th byte: `header_valid`=`packet_done`=1, `data_type`=0, `virtual_channel`=0, `word_count`=1, `ecc`=8'h07.
  - No `payload_valid`.
  - `phy_reset` high for the next 4 cycles.
- Long packet, bytes 8'h6A, 8'h03, 8'h00, 8'h11, then 8'hAA, 8'hBB, 8'hCC, then 8'h34, 8'h12, with `rx_enable` gaps of 0–3 cycles:
  - `virtual_channel`=1, `data_type`=6'h2A, `word_count`=3.
  - Exactly 3 `payload_valid` pulses carrying AA, BB, CC.
  - `footer`=16'h1234, one `packet_done`.
- Long packet with `word_count`=0 (8'h2A, 8'h00, 8'h00, ecc, then 8'h01, 8'h02) → zero `payload_valid` pulses, `footer`=16'h0201, `packet_done`.
- Timeout: two header bytes, then idle → `timeout_error` pulse exactly 64 cycles after the last byte, then 4 cycles of `phy_reset`, no `packet_done`. Repeat with a byte arriving at gap cycle 63 → no timeout.
- Assert `reset` asynchronously mid-PAYLOAD (between clock edges) → `phy_reset`=1 and pulses 0 immediately. After release, a full long packet parses correctly.

Source files
------------

// File: rtl/csi_packet_controller.sv
// CSI-2 packet-level sequencer for one D-PHY data lane receiver.
// Parses the 4-byte header, counts payload bytes, captures the 2-byte
// footer, then holds the lane receiver in reset so it re-arms on the next
// sync byte. A byte-gap timeout aborts packets on a stalled lane.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RESYNC  | phy_reset held high for RESYNC_CYCLES, rx_enable ignored
// S_IDLE    | waiting for header byte0 (VC / data type)
// S_HEADER  | collecting header bytes 1..3 (word count, ecc)
// S_PAYLOAD | passing through word_count payload bytes
// S_FOOTER  | collecting the 2 checksum bytes
module csi_packet_controller #(
  parameter int RESYNC_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic        phy_reset,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic        header_valid,
  output logic [7:0]  payload,
  output logic        payload_valid,
  output logic [15:0] footer,
  output logic        packet_done,
  output logic        timeout_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_FOOTER,
    S_RESYNC
  } state_t;

  localparam logic [7:0]  RESYNC_LAST  = 8'(RESYNC_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  resync_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] remaining;
  logic [1:0]  hdr_idx;
  logic        foot_idx;
  logic        mid_packet;

  assign mid_packet = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_FOOTER);

  // Packet FSM with registered outputs; the gap timeout is evaluated last so
  // an expiring timer overrides the (idle) per-state behaviour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_RESYNC;
      resync_cnt      <= 8'd0;
      gap_cnt         <= 16'd0;
      remaining       <= 16'd0;
      hdr_idx         <= 2'd0;
      foot_idx        <= 1'b0;
      phy_reset       <= 1'b1;
      virtual_channel <= 2'd0;
      data_type       <= 6'd0;
      word_count      <= 16'd0;
      ecc             <= 8'd0;
      header_valid    <= 1'b0;
      payload         <= 8'd0;
      payload_valid   <= 1'b0;
      footer          <= 16'd0;
      packet_done     <= 1'b0;
      timeout_error   <= 1'b0;
    end else begin
      header_valid  <= 1'b0;
      payload_valid <= 1'b0;
      packet_done   <= 1'b0;
      timeout_error <= 1'b0;

      case (state)
        S_RESYNC: begin
          if (resync_cnt == RESYNC_LAST) begin
            state      <= S_IDLE;
            phy_reset  <= 1'b0;
            resync_cnt <= 8'd0;
          end else begin
            resync_cnt <= resync_cnt + 8'd1;
          end
        end

        S_IDLE: begin
          if (rx_enable) begin
            virtual_channel <= rx_data[7:6];
            data_type       <= rx_data[5:0];
            hdr_idx         <= 2'd1;
            gap_cnt         <= 16'd0;
            state           <= S_HEADER;
          end
        end

        S_HEADER: begin
          if (rx_enable) begin
            case (hdr_idx)
              2'd1: begin
                word_count[7:0] <= rx_data;
                hdr_idx         <= 2'd2;
              end
              2'd2: begin
                word_count[15:8] <= rx_data;
                hdr_idx          <= 2'd3;
              end
              default: begin
                ecc          <= rx_data;
                header_valid <= 1'b1;
                if (data_type < 6'h10) begin
                  // short packet: no payload or footer follows
                  packet_done <= 1'b1;
                  phy_reset   <= 1'b1;
                  resync_cnt  <= 8'd0;
                  state       <= S_RESYNC;
                end else if (word_count == 16'd0) begin
                  foot_idx <= 1'b0;
                  state    <= S_FOOTER;
                end else begin
                  remaining <= word_count;
                  state     <= S_PAYLOAD;
                end
              end
            endcase
          end
        end

        S_PAYLOAD: begin
          if (rx_enable) begin
            payload       <= rx_data;
            payload_valid <= 1'b1;
            remaining     <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              foot_idx <= 1'b0;
              state    <= S_FOOTER;
            end
          end
        end

        S_FOOTER: begin
          if (rx_enable) begin
            if (!foot_idx) begin
              footer[7:0] <= rx_data;
              foot_idx    <= 1'b1;
            end else begin
              footer[15:8] <= rx_data;
              packet_done  <= 1'b1;
              phy_reset    <= 1'b1;
              resync_cnt   <= 8'd0;
              state        <= S_RESYNC;
            end
          end
        end

        default: begin
          phy_reset  <= 1'b1;
          resync_cnt <= 8'd0;
          state      <= S_RESYNC;
        end
      endcase

      // A byte arriving on the limiting cycle wins over the timeout.
      if (mid_packet) begin
        if (rx_enable) begin
          gap_cnt <= 16'd0;
        end else if (gap_cnt == TIMEOUT_LAST) begin
          gap_cnt       <= 16'd0;
          timeout_error <= 1'b1;
          phy_reset     <= 1'b1;
          resync_cnt    <= 8'd0;
          state         <= S_RESYNC;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csi_packet_controller.sv
// Scoreboard bench for csi_packet_controller: stimulus pushes expected
// pulse events, a negedge monitor pops and compares them as they appear.
module tb_csi_packet_controller;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_enable;
  logic        phy_reset;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        header_valid;
  logic [7:0]  payload;
  logic        payload_valid;
  logic [15:0] footer;
  logic        packet_done;
  logic        timeout_error;

  csi_packet_controller #(
    .RESYNC_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_enable      (rx_enable),
    .phy_reset      (phy_reset),
    .virtual_channel(virtual_channel),
    .data_type      (data_type),
    .word_count     (word_count),
    .ecc            (ecc),
    .header_valid   (header_valid),
    .payload        (payload),
    .payload_valid  (payload_valid),
    .footer         (footer),
    .packet_done    (packet_done),
    .timeout_error  (timeout_error)
  );

  typedef struct {
    logic        hv, pv, pd, te;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
    logic [7:0]  pl;
    logic [15:0] ft;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.hv = 0; e.pv = 0; e.pd = 0; e.te = 0;
    e.vc = 0; e.dt = 0; e.wc = 0; e.ecc = 0; e.pl = 0; e.ft = 0;
    return e;
  endfunction

  task automatic push_hdr(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input logic [7:0] e8, input logic is_short);
    exp_t e = blank();
    e.hv = 1; e.pd = is_short; e.vc = vc; e.dt = dt; e.wc = wc; e.ecc = e8;
    exp_q.push_back(e);
  endtask

  task automatic push_pl(input logic [7:0] b);
    exp_t e = blank();
    e.pv = 1; e.pl = b;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [15:0] ft);
    exp_t e = blank();
    e.pd = 1; e.ft = ft;
    exp_q.push_back(e);
  endtask

  task automatic push_to();
    exp_t e = blank();
    e.te = 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the next queued event.
  always @(negedge clock) begin
    if (header_valid || payload_valid || packet_done || timeout_error) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'({header_valid, payload_valid, packet_done, timeout_error}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulses", 32'({header_valid, payload_valid, packet_done, timeout_error}),
            32'({e.hv, e.pv, e.pd, e.te}));
        if (e.hv) begin
          chk("virtual_channel", 32'(virtual_channel), 32'(e.vc));
          chk("data_type", 32'(data_type), 32'(e.dt));
          chk("word_count", 32'(word_count), 32'(e.wc));
          chk("ecc", 32'(ecc), 32'(e.ecc));
        end
        if (e.pv) chk("payload", 32'(payload), 32'(e.pl));
        if (e.pd && !e.hv) chk("footer", 32'(footer), 32'(e.ft));
      end
    end
  end

  // Called at a negedge; the byte is sampled by the posedge after gap_before idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap_before);
    rx_enable = 1'b0;
    repeat (gap_before) @(negedge clock);
    rx_data   = b;
    rx_enable = 1'b1;
    @(negedge clock);
    rx_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (phy_reset && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("resync_len", 32'(n), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset     = 1'b1;
    rx_enable = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(negedge clock);

    // reset state
    chk("rst_phy_reset", 32'(phy_reset), 32'd1);
    chk("rst_pulses", 32'({header_valid, payload_valid, packet_done, timeout_error}), 32'd0);
    chk("rst_hdr", 32'({virtual_channel, data_type, word_count, ecc}), 32'd0);
    chk("rst_pl_ft", 32'({payload, footer}), 32'd0);
    reset = 1'b0;
    wait_idle();
    chk("idle_phy_reset", 32'(phy_reset), 32'd0);

    // short packet
    push_hdr(2'd0, 6'h00, 16'h0001, 8'h07, 1'b1);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    wait_idle();

    // long packet with byte gaps
    push_hdr(2'd1, 6'h2A, 16'h0003, 8'h11, 1'b0);
    push_pl(8'hAA); push_pl(8'hBB); push_pl(8'hCC);
    push_done(16'h1234);
    send_byte(8'h6A, 0); send_byte(8'h03, 1); send_byte(8'h00, 2); send_byte(8'h11, 3);
    send_byte(8'hAA, 0); send_byte(8'hBB, 2); send_byte(8'hCC, 3);
    send_byte(8'h34, 1); send_byte(8'h12, 2);
    wait_idle();

    // long packet with zero word count
    push_hdr(2'd0, 6'h2A, 16'h0000, 8'h5C, 1'b0);
    push_done(16'h0201);
    send_byte(8'h2A, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h5C, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    wait_idle();

    // timeout after two header bytes
    push_to();
    send_byte(8'h2A, 0); send_byte(8'h05, 0);
    k = 0;
    while (!timeout_error && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("timeout_gap", 32'(k), 32'd64);
    wait_idle();

    // byte on the last gap cycle wins, packet completes normally
    push_hdr(2'd0, 6'h2A, 16'h0000, 8'h55, 1'b0);
    push_done(16'h0403);
    send_byte(8'h2A, 0); send_byte(8'h00, 0); send_byte(8'h00, 63); send_byte(8'h55, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    wait_idle();

    // async reset mid-payload
    push_hdr(2'd1, 6'h2A, 16'h0003, 8'h11, 1'b0);
    push_pl(8'hAA);
    send_byte(8'h6A, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    send_byte(8'hAA, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_phy_reset", 32'(phy_reset), 32'd1);
    chk("async_pulses", 32'({header_valid, payload_valid, packet_done, timeout_error}), 32'd0);
    @(negedge clock);
    chk("async_hdr", 32'({virtual_channel, data_type, word_count, ecc}), 32'd0);
    chk("async_pl_ft", 32'({payload, footer}), 32'd0);
    reset = 1'b0;
    wait_idle();

    // full long packet after reset
    push_hdr(2'd3, 6'h24, 16'h0002, 8'h3C, 1'b0);
    push_pl(8'h5A); push_pl(8'hA5);
    push_done(16'hBEEF);
    send_byte(8'hE4, 0); send_byte(8'h02, 0); send_byte(8'h00, 1); send_byte(8'h3C, 0);
    send_byte(8'h5A, 2); send_byte(8'hA5, 0); send_byte(8'hEF, 0); send_byte(8'hBE, 1);
    wait_idle();

    repeat (4) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
